// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state encoding and counter sizing for serial_adder
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width: $clog2(width), never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/full_adder.sv
// full_adder: single-bit full adder from two half adders and an OR gate
// Ports:
//   i_a, i_b : addend bits
//   i_cin    : carry in
//   o_sum    : sum bit
//   o_carry  : carry out
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_carry
);

    logic s0, c0, c1;

    half_adder u_ha0 (.i_a(i_a), .i_b(i_b),   .o_sum(s0),    .o_carry(c0));
    half_adder u_ha1 (.i_a(s0),  .i_b(i_cin), .o_sum(o_sum), .o_carry(c1));

    // At most one of the two half-adder carries can be set, so OR suffices.
    assign o_carry = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: single-bit half adder cell
// Ports:
//   i_a, i_b : addend bits
//   o_sum    : i_a xor i_b
//   o_carry  : i_a and i_b
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one full adder cell
// Ports:
//   i_clk, i_rst_n   : clock, asynchronous active-low reset
//   i_start          : begin an addition (sampled only in IDLE)
//   i_a, i_b, i_cin  : operands and carry-in, captured on the accepting edge
//   o_ready          : idle, can accept i_start
//   o_busy           : addition in progress or result being presented
//   o_done           : one-cycle pulse when o_sum/o_cout are updated
//   o_sum, o_cout    : last result, held until the next DONE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_ready,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d;
    logic             fa_s, fa_c, last;
    logic [WIDTH-1:0] s_shift;

    full_adder u_fa (
        .i_a    (a_q[0]),
        .i_b    (b_q[0]),
        .i_cin  (c_q),
        .o_sum  (fa_s),
        .o_carry(fa_c)
    );

    assign last = cnt_q == LAST;
    // New sum bit enters at the MSB; after WIDTH shifts the LSB sits at bit 0.
    assign s_shift = (s_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = i_start ? RUN : IDLE;
            RUN:     state_d = last ? DONE : RUN;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        o_ready = state_q == IDLE;
        o_busy  = state_q != IDLE;
        o_done  = state_q == DONE;
        o_sum   = sum_q;
        o_cout  = cout_q;
    end

    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        s_d    = s_q;
        c_d    = c_q;
        cnt_d  = cnt_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        if (state_q == IDLE && i_start) begin
            a_d   = i_a;
            b_d   = i_b;
            c_d   = i_cin;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d   = a_q >> 1;
            b_d   = b_q >> 1;
            s_d   = s_shift;
            c_d   = fa_c;
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                sum_d  = s_shift;
                cout_d = fa_c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= 1'b0;
            cnt_q  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            cnt_q  <= cnt_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH 1, 8 and 32
module tb_serial_adder;

    logic clk = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   fin_cnt = 0;

    always #5 clk = ~clk;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_w
        localparam int     W = (g == 0) ? 1 : (g == 1) ? 8 : 32;
        localparam longint M = (longint'(1) << W) - 1;

        logic         rst_n = 1'b0;
        logic         start = 1'b0;
        logic         cin = 1'b0;
        logic [W-1:0] a = '0;
        logic [W-1:0] b = '0;
        logic [W-1:0] sum;
        logic         ready, busy, done, cout;
        longint       exp_q[$];
        longint       due_q[$];
        longint       cyc = 0;
        longint       last = 0;
        int           busy_cnt = 0;

        serial_adder #(.WIDTH(W)) dut (
            .i_clk  (clk),
            .i_rst_n(rst_n),
            .i_start(start),
            .i_a    (a),
            .i_b    (b),
            .i_cin  (cin),
            .o_ready(ready),
            .o_busy (busy),
            .o_done (done),
            .o_sum  (sum),
            .o_cout (cout)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: pops the scoreboard whenever the DUT presents a result.
        always @(negedge clk) begin
            if (!rst_n) begin
                busy_cnt = 0;
                last = 0;
            end else begin
                busy_cnt = busy ? busy_cnt + 1 : 0;
                check($sformatf("w%0d_ready_vs_busy", W), ready, !busy);
                if (done) begin
                    if (exp_q.size() == 0) begin
                        check($sformatf("w%0d_spurious_done", W), 1, 0);
                    end else begin
                        check($sformatf("w%0d_result", W), {cout, sum}, exp_q.pop_front());
                        check($sformatf("w%0d_latency", W), cyc, due_q.pop_front());
                        check($sformatf("w%0d_busy_len", W), busy_cnt, W + 1);
                    end
                    last = {cout, sum};
                end else begin
                    check($sformatf("w%0d_result_hold", W), {cout, sum}, last);
                end
            end
        end

        task automatic wait_ready();
            int n = 0;
            while (!ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            check($sformatf("w%0d_ready_wait", W), ready, 1);
        endtask

        // Issue one addition; noisy scrambles inputs and pulses start while busy.
        task automatic add(input longint x, input longint y, input bit c, input bit noisy);
            wait_ready();
            a = W'(x);
            b = W'(y);
            cin = c;
            start = 1'b1;
            exp_q.push_back(((x & M) + (y & M) + longint'(c)) & ((M << 1) | 1));
            due_q.push_back(cyc + 1 + W);
            @(negedge clk);
            for (int i = 0; i < W; i++) begin
                start = noisy ? 1'($urandom) : 1'b0;
                a = noisy ? W'($urandom) : a;
                b = noisy ? W'($urandom) : b;
                cin = noisy ? 1'($urandom) : cin;
                @(negedge clk);
            end
            start = 1'b0;
        endtask

        task automatic rst_check(input string tag);
            rst_n = 1'b0;
            exp_q.delete();
            due_q.delete();
            #1;
            check($sformatf("w%0d_%s_result", W, tag), {cout, sum}, 0);
            check($sformatf("w%0d_%s_done", W, tag), done, 0);
            check($sformatf("w%0d_%s_busy", W, tag), busy, 0);
            check($sformatf("w%0d_%s_ready", W, tag), ready, 1);
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
        endtask

        task automatic mid_reset();
            wait_ready();
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'b1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat ((W > 4) ? 4 : 0) @(negedge clk);
            rst_check("midrun_rst");
        endtask

        initial begin
            @(negedge clk);
            rst_check("por");
            @(negedge clk);
            add(64'h5A, 64'h3C, 1'b0, 1'b0);
            add(64'h5A, 64'h3C, 1'b0, 1'b1);
            add(64'hFF, 64'h01, 1'b0, 1'b0);
            add(64'hFF, 64'hFF, 1'b1, 1'b0);
            add(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b1);
            wait_ready();
            rst_check("idle_rst");
            mid_reset();
            add(64'h01, 64'h02, 1'b0, 1'b0);
            repeat (1000) add(longint'($urandom), longint'($urandom), 1'($urandom), 1'($urandom));
            for (int i = 0; i < W + 5 && exp_q.size() > 0; i++) @(negedge clk);
            check($sformatf("w%0d_drain", W), exp_q.size(), 0);
            fin_cnt++;
        end
    end

    initial begin
        for (int i = 0; i < 60000 && fin_cnt < 3; i++) @(posedge clk);
        check("finish_timeout", fin_cnt, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
